vme_cmd_responder: RTL and testbench

//  Target side of the simulation/bring-up VME command channel. Accepts one 32-bit command word plus 32-bit data per

---
 rtl/vme_cmd_responder_if.sv | 32 +++
 rtl/vme_cmd_responder.sv | 119 +++++++++++
 tb/tb_vme_cmd_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vme_cmd_responder_if.sv
// Command channel and register-bus signals between the VME command source and
// vme_cmd_responder. dbg_state mirrors the responder FSM for observation.
interface vme_cmd_responder_if;
    // Handshakes: a command transfers on the clk edge where start && vme_cmd_rd;
    // vme_dat_wr is a one-cycle response strobe with no back-pressure;
    // bus_strobe is held until the clk edge where bus_ack is sampled high (or timeout).
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic        bus_strobe;
    logic        bus_write;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic [1:0]  dbg_state;

    modport master (
        output start, vme_cmd_reg, vme_dat_reg_in, bus_ack, bus_rdata,
        input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
        input  bus_strobe, bus_write, bus_addr, bus_wdata, dbg_state
    );

    modport slave (
        input  start, vme_cmd_reg, vme_dat_reg_in, bus_ack, bus_rdata,
        output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out,
        output bus_strobe, bus_write, bus_addr, bus_wdata, dbg_state
    );
endinterface

// File: rtl/vme_cmd_responder.sv
// Target side of the VME command channel: decodes one command word and runs a
// single read or write on the 16-bit register bus, returning one response word.
module vme_cmd_responder #(
    parameter logic [7:0]  BOARD_TAG = 8'hA8,
    parameter logic [7:0]  TIMEOUT   = 8'd255,
    parameter logic [15:0] TO_DATA   = 16'hDEAD
) (
    input logic                clk,
    input logic                rst_n,
    vme_cmd_responder_if.slave vif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        BUS    = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [25:0] cmd_q;
    logic [15:0] wdat_q;
    logic [7:0]  to_cnt;
    logic        is_read;
    logic        cmd_valid;
    logic        bus_timeout;
    logic        load_resp;
    logic [31:0] resp_word;
    logic        unused_bits;

    assign unused_bits = ^{vif.vme_cmd_reg[31:26], vif.vme_dat_reg_in[31:16]};

    assign is_read     = cmd_q[25] & ~cmd_q[24];
    assign cmd_valid   = (cmd_q[25] ^ cmd_q[24]) && (cmd_q[23:16] == BOARD_TAG);
    // An ack on the final allowed cycle still wins over the timeout.
    assign bus_timeout = !vif.bus_ack && ((to_cnt + 8'd1) == TIMEOUT);
    assign vif.dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        vif.vme_cmd_rd = 1'b0;
        vif.vme_dat_wr = 1'b0;
        load_resp      = 1'b0;
        resp_word      = '0;
        case (state)
            IDLE: begin
                vif.vme_cmd_rd = 1'b1;
                if (vif.start) state_next = DECODE;
            end
            DECODE: begin
                if (cmd_valid) begin
                    state_next = BUS;
                end else begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                    resp_word  = {13'd0, is_read, 1'b1, 1'b0, TO_DATA};
                end
            end
            BUS: begin
                if (vif.bus_ack) begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                    resp_word  = {13'd0, is_read, 1'b0, 1'b0,
                                  is_read ? vif.bus_rdata : wdat_q};
                end else if (bus_timeout) begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                    resp_word  = {13'd0, is_read, 1'b0, 1'b1, TO_DATA};
                end
            end
            RESP: begin
                vif.vme_dat_wr = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q               <= '0;
            wdat_q              <= '0;
            to_cnt              <= '0;
            vif.bus_strobe      <= 1'b0;
            vif.bus_write       <= 1'b0;
            vif.bus_addr        <= '0;
            vif.bus_wdata       <= '0;
            vif.vme_dat_reg_out <= '0;
        end else begin
            if (state == IDLE && vif.start) begin
                cmd_q  <= vif.vme_cmd_reg[25:0];
                wdat_q <= vif.vme_dat_reg_in[15:0];
            end
            if (state == DECODE && cmd_valid) begin
                vif.bus_strobe <= 1'b1;
                vif.bus_write  <= cmd_q[24];
                vif.bus_addr   <= cmd_q[15:0];
                vif.bus_wdata  <= wdat_q;
                to_cnt         <= '0;
            end
            if (state == BUS) begin
                to_cnt <= to_cnt + 8'd1;
                if (vif.bus_ack || bus_timeout) vif.bus_strobe <= 1'b0;
            end
            // The response word is registered on entry to RESP so it is valid with vme_dat_wr.
            if (load_resp) vif.vme_dat_reg_out <= resp_word;
        end
    end

endmodule

// File: tb/tb_vme_cmd_responder.sv
// Directed bench for vme_cmd_responder: write, read, timeout, decode errors,
// back-to-back commands and reset during a bus cycle.
module tb_vme_cmd_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vme_cmd_responder_if vif();

  vme_cmd_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_mem [0:63];
  int resp_cnt = 0;
  int rd_idx = 0;
  int strobe_cycles = 0;
  int double_wr = 0;
  logic prev_wr = 1'b0;

  logic ack_en = 1'b0;
  int ack_delay = 0;
  logic [15:0] ack_rdata = 16'h0;
  int ack_wait = 0;

  logic [31:0] bb_cmd [3] = '{32'h01A85000, 32'h02A85002, 32'h00A85004};
  logic [31:0] bb_dat [3] = '{32'hFFFF1234, 32'h00000000, 32'h00000000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: records every response word and counts strobe cycles.
  always @(negedge clk) begin
    if (vif.vme_dat_wr) begin
      if (resp_cnt < 64) obs_mem[resp_cnt] = vif.vme_dat_reg_out;
      resp_cnt++;
      if (prev_wr) double_wr++;
    end
    if (vif.bus_strobe) strobe_cycles++;
    prev_wr = vif.vme_dat_wr;
  end

  // Register-bus target model: one-cycle ack after ack_delay strobe cycles.
  always @(negedge clk) begin
    if (ack_en && vif.bus_strobe && !vif.bus_ack) begin
      if (ack_wait == ack_delay) begin
        vif.bus_ack   = 1'b1;
        vif.bus_rdata = ack_rdata;
        ack_wait      = 0;
      end else begin
        vif.bus_ack = 1'b0;
        ack_wait++;
      end
    end else begin
      vif.bus_ack   = 1'b0;
      vif.bus_rdata = 16'h0;
      ack_wait      = 0;
    end
  end

  task automatic issue(input logic [31:0] cmd, input logic [31:0] dat);
    int c = 0;
    @(negedge clk);
    while (!vif.vme_cmd_rd && c < 300) begin
      @(negedge clk);
      c++;
    end
    check_eq("cmd_rd_wait", vif.vme_cmd_rd, 1);
    vif.start = 1'b1;
    vif.vme_cmd_reg = cmd;
    vif.vme_dat_reg_in = dat;
    @(negedge clk);
    vif.start = 1'b0;
  endtask

  task automatic wait_strobe();
    int c = 0;
    while (!vif.bus_strobe && c < 10) begin
      @(negedge clk);
      c++;
    end
    check_eq("strobe_rise", vif.bus_strobe, 1);
  endtask

  task automatic wait_resp(input int target);
    int c = 0;
    while (resp_cnt < target && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    check_eq("resp_arrive", resp_cnt, target);
  endtask

  task automatic drain();
    while (rd_idx < resp_cnt && rd_idx < 64) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", resp_cnt, rd_idx);
        rd_idx = resp_cnt;
      end else begin
        check_eq("resp_word", obs_mem[rd_idx], exp_q.pop_front());
        rd_idx++;
      end
    end
    check_eq("resp_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_rd"}, vif.vme_cmd_rd, 1);
    check_eq({tag, "_dat_wr"}, vif.vme_dat_wr, 0);
    check_eq({tag, "_dat_out"}, vif.vme_dat_reg_out, 0);
    check_eq({tag, "_strobe"}, vif.bus_strobe, 0);
    check_eq({tag, "_write"}, vif.bus_write, 0);
    check_eq({tag, "_addr"}, vif.bus_addr, 0);
    check_eq({tag, "_wdata"}, vif.bus_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    int k;

    vif.start = 1'b0;
    vif.vme_cmd_reg = 32'h0;
    vif.vme_dat_reg_in = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Write with ack two cycles after strobe
    ack_en = 1'b1;
    ack_delay = 2;
    base = resp_cnt;
    exp_q.push_back(32'h00000011);
    issue(32'h01A83000, 32'h00000011);
    wait_strobe();
    check_eq("wr_bus_write", vif.bus_write, 1);
    check_eq("wr_bus_addr", vif.bus_addr, 32'h3000);
    check_eq("wr_bus_wdata", vif.bus_wdata, 32'h0011);
    wait_resp(base + 1);
    check_eq("wr_strobe_drop", vif.bus_strobe, 0);
    repeat (3) @(negedge clk);
    check_eq("wr_resp_hold", vif.vme_dat_reg_out, 32'h00000011);
    check_eq("wr_idle", vif.vme_cmd_rd, 1);
    drain();

    // Read with zero-wait ack, cycle-accurate latency
    ack_delay = 0;
    ack_rdata = 16'hBEEF;
    exp_q.push_back(32'h0004BEEF);
    issue(32'h02A84100, 32'h0000FFFF);
    check_eq("rd_lat_busy", vif.vme_cmd_rd, 0);
    check_eq("rd_lat_no_wr", vif.vme_dat_wr, 0);
    @(negedge clk);
    check_eq("rd_lat_strobe", vif.bus_strobe, 1);
    check_eq("rd_bus_write", vif.bus_write, 0);
    check_eq("rd_bus_addr", vif.bus_addr, 32'h4100);
    @(negedge clk);
    check_eq("rd_lat_wr", vif.vme_dat_wr, 1);
    check_eq("rd_lat_strobe_drop", vif.bus_strobe, 0);
    @(negedge clk);
    check_eq("rd_lat_wr_pulse", vif.vme_dat_wr, 0);
    check_eq("rd_lat_cmd_rd", vif.vme_cmd_rd, 1);
    drain();

    // Timeout: no ack, strobe held for exactly 255 cycles
    ack_en = 1'b0;
    base = resp_cnt;
    exp_q.push_back(32'h0005DEAD);
    issue(32'h02A84200, 32'h00000000);
    wait_strobe();
    n = 0;
    while (vif.bus_strobe && n < 300) begin
      n++;
      @(negedge clk);
    end
    check_eq("to_cycles", n, 255);
    wait_resp(base + 1);
    drain();

    // Decode errors: both bits, neither bit, wrong tag
    foreach (bb_cmd[i]) begin
      logic [31:0] dcmd;
      int sbase;
      case (i)
        0: dcmd = 32'h03A80000;
        1: dcmd = 32'h00A80000;
        default: dcmd = 32'h01A70000;
      endcase
      sbase = strobe_cycles;
      base = resp_cnt;
      exp_q.push_back(32'h0002DEAD);
      issue(dcmd, 32'h00001234);
      check_eq("dec_lat_no_wr", vif.vme_dat_wr, 0);
      @(negedge clk);
      check_eq("dec_lat_wr", vif.vme_dat_wr, 1);
      wait_resp(base + 1);
      check_eq("dec_no_strobe", strobe_cycles, sbase);
    end
    drain();

    // Back-to-back: start held high across three commands
    ack_en = 1'b1;
    ack_delay = 0;
    ack_rdata = 16'h5678;
    exp_q.push_back(32'h00001234);
    exp_q.push_back(32'h00045678);
    exp_q.push_back(32'h0002DEAD);
    base = resp_cnt;
    @(negedge clk);
    check_eq("bb_start_idle", vif.vme_cmd_rd, 1);
    vif.start = 1'b1;
    vif.vme_cmd_reg = bb_cmd[0];
    vif.vme_dat_reg_in = bb_dat[0];
    k = 1;
    for (int c = 0; c < 100 && k < 4; c++) begin
      @(negedge clk);
      if (vif.vme_cmd_rd) begin
        if (k < 3) begin
          vif.vme_cmd_reg = bb_cmd[k];
          vif.vme_dat_reg_in = bb_dat[k];
        end else begin
          vif.start = 1'b0;
        end
        k++;
      end
    end
    vif.start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("bb_count", resp_cnt - base, 3);
    drain();

    // Reset during a bus cycle aborts without a response
    ack_en = 1'b0;
    base = resp_cnt;
    issue(32'h02A86000, 32'h00000000);
    wait_strobe();
    repeat (3) @(negedge clk);
    check_eq("rst_pre_strobe", vif.bus_strobe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    check_eq("rst_no_resp", resp_cnt, base);
    ack_en = 1'b1;
    ack_delay = 1;
    base = resp_cnt;
    exp_q.push_back(32'h00000055);
    issue(32'h01A86002, 32'h00000055);
    wait_strobe();
    check_eq("post_rst_write", vif.bus_write, 1);
    check_eq("post_rst_addr", vif.bus_addr, 32'h6002);
    check_eq("post_rst_wdata", vif.bus_wdata, 32'h0055);
    wait_resp(base + 1);
    drain();

    check_eq("wr_single_cycle", double_wr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
